array_stream_reader: RTL and testbench

//  Read side for the labelled register array written by the array write logic.

---
 rtl/array_stream_reader.sv | 153 +++++++++++++++
 tb/tb_array_stream_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/array_stream_reader.sv
// Streams a wrapped run of labelled array entries over valid/ready.
// Define ARRAY_RD_TAG_FILTER_EN to blank the data of H-tagged beats.
module array_stream_reader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [IDX_W-1:0]       start_idx,
    input  logic [IDX_W:0]         count,
    input  logic                   abort,
    input  logic [DEPTH*WIDTH-1:0] arr_data,
    input  logic [DEPTH-1:0]       arr_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_tag,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IDX_W:0] LP_DEPTH = (IDX_W + 1)'(DEPTH);

    state_t             r_state, w_state;
    logic               r_valid, w_valid;
    logic [WIDTH-1:0]   r_data, w_data;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic               r_tag, w_tag;
    logic               r_last, w_last;
    logic [IDX_W:0]     r_rem, w_rem;
    logic               r_done, w_done;
    logic               r_err, w_err;

    logic [WIDTH-1:0]   w_ent [DEPTH];
    logic [IDX_W-1:0]   w_rd_idx;
    logic [WIDTH-1:0]   w_raw;
    logic               w_rd_tag;
    logic [WIDTH-1:0]   w_beat;
    logic               w_hs;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign w_ent[g] = arr_data[g*WIDTH +: WIDTH];
    end

    assign w_raw    = w_ent[w_rd_idx];
    assign w_rd_tag = arr_tag[w_rd_idx];
    assign w_hs     = r_valid & out_ready;

`ifdef ARRAY_RD_TAG_FILTER_EN
    // H contents never reach the data bus; the tag still goes out
    assign w_beat = w_rd_tag ? '0 : w_raw;
`else
    assign w_beat = w_raw;
`endif

    always_comb begin
        w_state  = r_state;
        w_valid  = r_valid;
        w_data   = r_data;
        w_idx    = r_idx;
        w_tag    = r_tag;
        w_last   = r_last;
        w_rem    = r_rem;
        w_done   = 1'b0;
        w_err    = 1'b0;
        w_rd_idx = r_idx + 1'b1;
        unique case (r_state)
            IDLE: begin
                w_rd_idx = start_idx;
                if (start) begin
                    if (count != '0 && count <= LP_DEPTH) begin
                        w_state = SEND;
                        w_valid = 1'b1;
                        w_idx   = start_idx;
                        w_data  = w_beat;
                        w_tag   = w_rd_tag;
                        w_rem   = count;
                        w_last  = (count == 1);
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    w_state = IDLE;
                    w_valid = 1'b0;
                    w_last  = 1'b0;
                    w_rem   = '0;
                end else if (w_hs) begin
                    if (r_rem == 1) begin
                        w_state = IDLE;
                        w_valid = 1'b0;
                        w_last  = 1'b0;
                        w_rem   = '0;
                        w_done  = 1'b1;
                    end else begin
                        w_idx  = w_rd_idx;
                        w_data = w_beat;
                        w_tag  = w_rd_tag;
                        w_rem  = r_rem - 1'b1;
                        w_last = (r_rem == 2);
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_tag   <= 1'b0;
            r_last  <= 1'b0;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_valid <= w_valid;
            r_data  <= w_data;
            r_idx   <= w_idx;
            r_tag   <= w_tag;
            r_last  <= w_last;
            r_rem   <= w_rem;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_tag   = r_tag;
    assign out_last  = r_last;
    assign busy      = (r_state == SEND);
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_array_stream_reader.sv
// Directed checks for array_stream_reader: bursts, wrap, stalls,
// rejected starts, abort and tag handling.
module tb_array_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  start_idx;
    logic [2:0]  count;
    logic        abort;
    logic [63:0] arr_data;
    logic [3:0]  arr_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        out_tag;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    int ncmp = 0;
    int nfail = 0;

    array_stream_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .start_idx (start_idx),
        .count     (count),
        .abort     (abort),
        .arr_data  (arr_data),
        .arr_tag   (arr_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_tag   (out_tag),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {valid,busy,last,done,err}
    function automatic logic [4:0] flags();
        return {out_valid, busy, out_last, done, err};
    endfunction

    logic [15:0] exp_beef;

    initial begin
`ifdef ARRAY_RD_TAG_FILTER_EN
        exp_beef = 16'h0000;
`else
        exp_beef = 16'hBEEF;
`endif
        reset     = 1'b0;
        start     = 1'b0;
        start_idx = '0;
        count     = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        arr_data  = {16'hA333, 16'hA222, 16'hA111, 16'hA000};
        arr_tag   = 4'b0000;
        tick;
        chk("reset_flags", 32'(flags()), 32'h0);
        chk("reset_data", 32'(out_data), 32'h0);
        reset = 1'b1;
        tick;

        // 1: reset mid-burst
        start = 1'b1; start_idx = 2'd2; count = 3'd4;
        tick;
        start = 1'b0;
        chk("t1_valid_busy", 32'(flags()), 32'b11000);
        chk("t1_data", 32'(out_data), 32'hA222);
        #2 reset = 1'b0;
        #1;
        chk("t1_async_flags", 32'(flags()), 32'h0);
        chk("t1_async_data", 32'({out_data, out_idx, out_tag}), 32'h0);
        reset = 1'b1;
        tick;
        chk("t1_idle_after", 32'(flags()), 32'h0);

        // 2: start 1, count 2, ready high
        start = 1'b1; start_idx = 2'd1; count = 3'd2; out_ready = 1'b1;
        tick;
        start = 1'b0;
        chk("t2_b0_flags", 32'(flags()), 32'b11000);
        chk("t2_b0", 32'({out_idx, out_data}), {14'd0, 2'd1, 16'hA111});
        tick;
        chk("t2_b1_flags", 32'(flags()), 32'b11100);
        chk("t2_b1", 32'({out_idx, out_data}), {14'd0, 2'd2, 16'hA222});
        tick;
        chk("t2_done", 32'(flags()), 32'b00010);
        tick;
        chk("t2_done_pulse", 32'(flags()), 32'b00000);

        // 3: wrap 3,0,1,2 with ready toggling
        out_ready = 1'b0;
        start = 1'b1; start_idx = 2'd3; count = 3'd4;
        tick;
        start = 1'b0;
        chk("t3_b0", 32'({out_idx, out_data}), {14'd0, 2'd3, 16'hA333});
        out_ready = 1'b1;
        tick;
        chk("t3_b1", 32'({out_idx, out_data}), {14'd0, 2'd0, 16'hA000});
        out_ready = 1'b0;
        start = 1'b1; count = 3'd0;
        tick;
        start = 1'b0;
        chk("t3_b1_hold", 32'({out_idx, out_data}), {14'd0, 2'd0, 16'hA000});
        chk("t3_start_in_send", 32'(flags()), 32'b11000);
        out_ready = 1'b1;
        tick;
        chk("t3_b2", 32'({out_idx, out_data}), {14'd0, 2'd1, 16'hA111});
        out_ready = 1'b0;
        tick;
        chk("t3_b2_hold", 32'({out_idx, out_data}), {14'd0, 2'd1, 16'hA111});
        out_ready = 1'b1;
        tick;
        chk("t3_b3", 32'({out_idx, out_data}), {14'd0, 2'd2, 16'hA222});
        chk("t3_b3_flags", 32'(flags()), 32'b11100);
        out_ready = 1'b0;
        tick;
        chk("t3_b3_hold", 32'(flags()), 32'b11100);
        out_ready = 1'b1;
        tick;
        chk("t3_done", 32'(flags()), 32'b00010);

        // 4: rejected starts
        start = 1'b1; start_idx = 2'd0; count = 3'd0;
        tick;
        start = 1'b0;
        chk("t4_err0", 32'(flags()), 32'b00001);
        tick;
        chk("t4_err0_pulse", 32'(flags()), 32'b00000);
        start = 1'b1; count = 3'd5;
        tick;
        start = 1'b0;
        chk("t4_err5", 32'(flags()), 32'b00001);
        tick;
        chk("t4_err5_pulse", 32'(flags()), 32'b00000);

        // 5: abort after second handshake
        start = 1'b1; start_idx = 2'd0; count = 3'd4;
        tick;
        start = 1'b0;
        tick;
        tick;
        chk("t5_b2", 32'({out_idx, out_data}), {14'd0, 2'd2, 16'hA222});
        out_ready = 1'b0; abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("t5_aborted", 32'(flags()), 32'b00000);
        tick;
        chk("t5_no_done", 32'(flags()), 32'b00000);
        start = 1'b1; start_idx = 2'd1; count = 3'd1;
        tick;
        start = 1'b0;
        chk("t5_restart", 32'(flags()), 32'b11100);
        chk("t5_restart_idx", 32'(out_idx), 32'd1);
        out_ready = 1'b1;
        tick;
        chk("t5_restart_done", 32'(flags()), 32'b00010);

        // 6: H-tagged entry, start during final handshake ignored
        out_ready = 1'b0;
        arr_tag = 4'b0100;
        arr_data[47:32] = 16'hBEEF;
        start = 1'b1; start_idx = 2'd2; count = 3'd1;
        tick;
        start = 1'b0;
        chk("t6_tag", 32'(out_tag), 32'd1);
        chk("t6_data", 32'(out_data), 32'(exp_beef));
        out_ready = 1'b1; start = 1'b1; count = 3'd2;
        tick;
        start = 1'b0;
        chk("t6_done", 32'(flags()), 32'b00010);
        tick;
        chk("t6_start_ignored", 32'(flags()), 32'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
